witness_driver: RTL and testbench

Stimulus engine for the two-counter assertion harness. From a pair of target values it drives the counter block's reset and enable inputs (`dut_rst`, `ena1`, `ena2`) so that `count`/`count2` land exactly on those targets. It then samples the assertion output `valid` and reports whether the assertion fired. It is the driving side of the `ena1`/`ena2`/`count`/`valid` interface: it replays a witness trace in simulation or on FPGA, which cross-checks formal results.

---
 rtl/witness_driver.sv | 116 +++++++++++
 tb/tb_witness_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/witness_driver.sv
// Drives the two-counter harness (dut_rst/ena1/ena2) so count/count2 land on the
// latched targets, then samples valid_obs. Optional WITNESS_CHECK_EN adds a count_obs shadow check.
module witness_driver #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target1,
  input  logic [WIDTH-1:0] target2,
  input  logic [WIDTH-1:0] count_obs,
  input  logic             valid_obs,
  output logic             dut_rst,
  output logic             ena1,
  output logic             ena2,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             mismatch
);

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    SETTLE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] t1_q, t2_q;
  logic [WIDTH-1:0] sh1_q, sh2_q;
  logic             dut_rst_q;
  logic             hit_q;
  logic             accept;

  assign accept  = (state_q == IDLE) && start;
  assign dut_rst = dut_rst_q;
  assign hit     = hit_q;

  always_comb begin
    state_d = state_q;
    ena1    = 1'b0;
    ena2    = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = RESET;
      RESET:  state_d = RUN;
      RUN: begin
        ena1 = (sh1_q != t1_q);
        ena2 = (sh2_q != t2_q);
        if ((sh1_q == t1_q) && (sh2_q == t2_q)) state_d = SETTLE;
      end
      SETTLE: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      t1_q      <= '0;
      t2_q      <= '0;
      sh1_q     <= '0;
      sh2_q     <= '0;
      dut_rst_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Registered so dut_rst is high exactly during the RESET state.
      dut_rst_q <= (state_d == RESET);
      if (accept) begin
        t1_q  <= target1;
        t2_q  <= target2;
        hit_q <= 1'b0;
      end
      if (state_q == RESET) begin
        sh1_q <= '0;
        sh2_q <= '0;
      end else begin
        if (ena1) sh1_q <= sh1_q + WIDTH'(1);
        if (ena2) sh2_q <= sh2_q + WIDTH'(1);
      end
      if (state_q == DONE) hit_q <= ~valid_obs;
    end
  end

`ifdef WITNESS_CHECK_EN
  logic mismatch_q;
  logic chk_active;

  assign chk_active = (state_q == RUN) || (state_q == SETTLE) || (state_q == DONE);
  assign mismatch   = mismatch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (accept) begin
      mismatch_q <= 1'b0;
    end else if (chk_active && (count_obs != sh1_q)) begin
      mismatch_q <= 1'b1;
    end
  end
`else
  logic unused_count_obs;

  assign unused_count_obs = ^count_obs;
  assign mismatch         = 1'b0;
`endif

endmodule

// File: tb/tb_witness_driver.sv
// Scoreboarded bench for witness_driver with a behavioural two-counter block
// whose assertion output drops only when both counters sit at all ones.
module tb_witness_driver;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] target1 = '0, target2 = '0;
  logic [W-1:0] count_obs;
  logic         valid_obs;
  logic         dut_rst, ena1, ena2, busy, done, hit, mismatch;

  logic [W-1:0] count = '0, count2 = '0;
  logic         inj = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lat;
    int e1;
    int e2;
    bit hit;
    bit mm;
  } exp_t;
  exp_t sb[$];

`ifdef WITNESS_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  witness_driver #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .target1(target1), .target2(target2),
    .count_obs(count_obs), .valid_obs(valid_obs),
    .dut_rst(dut_rst), .ena1(ena1), .ena2(ena2),
    .busy(busy), .done(done), .hit(hit), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Counter block under test: sync reset, independent enables.
  always_ff @(posedge clk) begin
    if (dut_rst) begin
      count  <= '0;
      count2 <= '0;
    end else begin
      if (ena1) count  <= count + 1'b1;
      if (ena2) count2 <= count2 + 1'b1;
    end
  end
  assign valid_obs = ~((&count) & (&count2));
  assign count_obs = inj ? count + 1'b1 : count;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input int t1, input int t2, input bit inject, input bit midstart);
    exp_t e, g;
    int   n, c1, c2, cr, m;
    bit   seen;
    m     = (t1 > t2) ? t1 : t2;
    e.lat = m + 3;
    e.e1  = t1;
    e.e2  = t2;
    e.hit = (t1 == 4095) && (t2 == 4095);
    e.mm  = inject && CHK_EN;
    sb.push_back(e);
    target1 = W'(t1);
    target2 = W'(t2);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; c1 = 0; c2 = 0; cr = 0; seen = 1'b0;
    check("cleared_hit", int'(hit), 0);
    check("cleared_mm", int'(mismatch), 0);
    check("busy_start", int'(busy), 1);
    while (n < 5000) begin
      if (dut_rst) cr++;
      if (ena1) c1++;
      if (ena2) c2++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
      inj = inject && (n == 4);
      if (midstart && n == 5) begin
        start = 1'b1; target1 = W'(7); target2 = W'(9);
      end else begin
        start = 1'b0;
      end
    end
    inj = 1'b0;
    check("timeout", int'(seen), 1);
    g = sb.pop_front();
    check("done_lat", n, g.lat);
    check("ena1_cyc", c1, g.e1);
    check("ena2_cyc", c2, g.e2);
    check("rst_cyc", cr, 1);
    check("busy_done", int'(busy), 1);
    check("mm_at_done", int'(mismatch), int'(g.mm));
    @(posedge clk); #1;
    check("hit", int'(hit), int'(g.hit));
    check("busy_idle", int'(busy), 0);
    check("mm_hold", int'(mismatch), int'(g.mm));
    if (midstart) begin
      c1 = 0;
      for (int i = 0; i < 4; i++) begin
        if (done || busy) c1++;
        @(posedge clk); #1;
      end
      check("single_done", c1, 0);
    end
  endtask

  initial begin
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_outs", int'({dut_rst, ena1, ena2, done, hit, mismatch}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run(3, 5, 1'b1, 1'b0);
    run(3, 5, 1'b0, 1'b0);
    run(0, 0, 1'b0, 1'b0);
    run(4095, 4095, 1'b0, 1'b0);
    run(4095, 4094, 1'b0, 1'b1);

    // Asynchronous reset ten cycles into a long run.
    target1 = W'(100); target2 = W'(100); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_outs", int'({dut_rst, ena1, ena2, busy, done, hit, mismatch}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run(2, 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
